gat_bram_loader: RTL

GAT_BRAM_LOADER -- requirements
Module: gat_bram_loader

---
 rtl/gat_pkg.sv | 38 +++
 rtl/gat_bram_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gat_pkg.sv
// Shared definitions for the GAT BRAM loader: frame header layout, target
// and FSM encodings.
package gat_pkg;

    localparam int CNT_W = 24;

    localparam int HDR_TGT_MSB = 31;
    localparam int HDR_TGT_LSB = 30;
    localparam int HDR_LEN_MSB = 23;
    localparam int HDR_LEN_LSB = 0;

    typedef enum logic [1:0] {
        TGT_H_DATA    = 2'd0,
        TGT_NODE_INFO = 2'd1,
        TGT_WEIGHT    = 2'd2,
        TGT_RSVD      = 2'd3
    } tgt_e;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Bit 0 = H data, bit 1 = node info, bit 2 = weight; reserved maps to none.
    function automatic logic [2:0] tgt_onehot(input tgt_e t);
        logic [2:0] oh;
        oh = '0;
        case (t)
            TGT_H_DATA:    oh = 3'b001;
            TGT_NODE_INFO: oh = 3'b010;
            TGT_WEIGHT:    oh = 3'b100;
            default:       oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/gat_bram_loader.sv
// Streams host frames (header + N payload words) into one of three BRAMs,
// with sticky per-target completion flags and sticky error flags.
module gat_bram_loader
    import gat_pkg::*;
#(
    parameter int TOP_WIDTH       = 32,
    parameter int H_DATA_DEPTH    = 242101,
    parameter int NODE_INFO_DEPTH = 13264,
    parameter int WEIGHT_DEPTH    = 22928,
    localparam int MAX_DEPTH01    = (H_DATA_DEPTH > NODE_INFO_DEPTH) ? H_DATA_DEPTH : NODE_INFO_DEPTH,
    localparam int MAX_DEPTH      = (MAX_DEPTH01 > WEIGHT_DEPTH) ? MAX_DEPTH01 : WEIGHT_DEPTH,
    localparam int ADDR_W         = $clog2(MAX_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic [TOP_WIDTH-1:0] s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tlast,

    input  logic                 load_clr,

    output logic [TOP_WIDTH-1:0] bram_din,
    output logic [ADDR_W+1:0]    bram_addra,

    output logic                 h_data_bram_ena,
    output logic                 h_data_bram_wea,
    output logic                 h_node_info_bram_ena,
    output logic                 h_node_info_bram_wea,
    output logic                 wgt_bram_ena,
    output logic                 wgt_bram_wea,

    output logic                 h_data_bram_load_done,
    output logic                 h_node_info_bram_load_done,
    output logic                 wgt_bram_load_done,

    output logic                 err_target,
    output logic                 err_len,
    output logic                 err_tlast
);

    state_e                 state_q, state_d;
    tgt_e                   tgt_q, tgt_d;
    logic [CNT_W-1:0]       len_q, len_d;
    logic [CNT_W-1:0]       idx_q, idx_d;
    logic [TOP_WIDTH-1:0]   din_q, din_d;
    logic [ADDR_W+1:0]      addra_q, addra_d;
    logic [2:0]             wr_q, wr_d;
    logic [2:0]             done_q, done_d;
    logic                   err_target_q, err_target_d;
    logic                   err_len_q, err_len_d;
    logic                   err_tlast_q, err_tlast_d;

    logic                   accept;
    logic [CNT_W-1:0]       depth_lim;
    logic [CNT_W-1:0]       idx_inc;
    tgt_e                   hdr_tgt;
    logic [CNT_W-1:0]       hdr_len;

    assign s_tready = (state_q != S_DONE);
    assign accept   = s_tvalid && s_tready;
    assign hdr_tgt  = tgt_e'(s_tdata[HDR_TGT_MSB:HDR_TGT_LSB]);
    assign hdr_len  = s_tdata[HDR_LEN_MSB:HDR_LEN_LSB];
    assign idx_inc  = idx_q + CNT_W'(1);

    always_comb begin
        depth_lim = '0;
        case (tgt_q)
            TGT_H_DATA:    depth_lim = CNT_W'(H_DATA_DEPTH);
            TGT_NODE_INFO: depth_lim = CNT_W'(NODE_INFO_DEPTH);
            TGT_WEIGHT:    depth_lim = CNT_W'(WEIGHT_DEPTH);
            default:       depth_lim = '0;
        endcase
    end

    // Flag set terms are computed alongside the FSM and merged below so a set
    // on the same cycle as load_clr takes priority.
    logic [2:0] done_set;
    logic       err_target_set, err_len_set, err_tlast_set;

    always_comb begin
        state_d        = state_q;
        tgt_d          = tgt_q;
        len_d          = len_q;
        idx_d          = idx_q;
        din_d          = din_q;
        addra_d        = addra_q;
        wr_d           = '0;
        done_set       = '0;
        err_target_set = 1'b0;
        err_len_set    = 1'b0;
        err_tlast_set  = 1'b0;

        case (state_q)
            S_HDR: begin
                if (accept) begin
                    tgt_d = hdr_tgt;
                    len_d = hdr_len;
                    idx_d = '0;
                    if (hdr_tgt == TGT_RSVD) begin
                        err_target_set = 1'b1;
                    end
                    if (hdr_len == '0) begin
                        state_d  = S_DONE;
                        done_set = tgt_onehot(hdr_tgt);
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (accept) begin
                    din_d   = s_tdata;
                    addra_d = {idx_q[ADDR_W-1:0], 2'b00};
                    idx_d   = idx_inc;
                    if (idx_q < depth_lim) begin
                        wr_d = tgt_onehot(tgt_q);
                    end else if (tgt_q != TGT_RSVD) begin
                        err_len_set = 1'b1;
                    end
                    if (idx_inc == len_q) begin
                        state_d  = S_DONE;
                        done_set = tgt_onehot(tgt_q);
                        if (!s_tlast) begin
                            err_tlast_set = 1'b1;
                        end
                    end else if (s_tlast) begin
                        err_tlast_set = 1'b1;
                        state_d       = S_HDR;
                    end
                end
            end

            S_DONE: begin
                state_d = S_HDR;
            end

            default: begin
                state_d = S_HDR;
            end
        endcase

        done_d       = done_set       | (load_clr ? 3'b000 : done_q);
        err_target_d = err_target_set | (!load_clr && err_target_q);
        err_len_d    = err_len_set    | (!load_clr && err_len_q);
        err_tlast_d  = err_tlast_set  | (!load_clr && err_tlast_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_HDR;
            tgt_q        <= TGT_H_DATA;
            len_q        <= '0;
            idx_q        <= '0;
            din_q        <= '0;
            addra_q      <= '0;
            wr_q         <= '0;
            done_q       <= '0;
            err_target_q <= 1'b0;
            err_len_q    <= 1'b0;
            err_tlast_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            din_q        <= din_d;
            addra_q      <= addra_d;
            wr_q         <= wr_d;
            done_q       <= done_d;
            err_target_q <= err_target_d;
            err_len_q    <= err_len_d;
            err_tlast_q  <= err_tlast_d;
        end
    end

    assign bram_din   = din_q;
    assign bram_addra = addra_q;

    assign h_data_bram_ena      = wr_q[0];
    assign h_data_bram_wea      = wr_q[0];
    assign h_node_info_bram_ena = wr_q[1];
    assign h_node_info_bram_wea = wr_q[1];
    assign wgt_bram_ena         = wr_q[2];
    assign wgt_bram_wea         = wr_q[2];

    assign h_data_bram_load_done      = done_q[0];
    assign h_node_info_bram_load_done = done_q[1];
    assign wgt_bram_load_done         = done_q[2];

    assign err_target = err_target_q;
    assign err_len    = err_len_q;
    assign err_tlast  = err_tlast_q;

endmodule
